seg7_scan_ctrl: RTL and testbench

- Time-multiplexes the shared 8-bit segment bus SEG_o between the two digits selected by COM_o on the ZYBO_TOP board.
- Gets digit data and control from a small write/read register port. The light52 I/O glue drives that port.
- Sequences each digit through a blanking gap and then an on-window, to suppress ghosting.
- Latches register contents per digit window, so a CPU write never tears a digit mid-display.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } seg7_state_e;

  localparam logic [1:0] ADDR_DIG0 = 2'd0;
  localparam logic [1:0] ADDR_DIG1 = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_RAW0 = 1;
  localparam int CTRL_RAW1 = 2;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble/dp or raw byte to an active-high segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       raw,
  input  logic [7:0] raw_byte,
  output logic [7:0] pattern
);

  assign pattern = raw ? raw_byte : {dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit multiplexed seven-segment driver with a small register port.
// Each digit gets a blanking gap, then an on-window showing a latched pattern.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_50MHz_i,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic [7:0]  SEG_o,
  output logic [1:0]  COM_o,
  output logic        frame_tick,
  output seg7_state_e dbg_state
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIGIT_LOAD = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [1:0] COM_OFF = COM_ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [7:0]       dig0_q, dig1_q, ctrl_q, rd_q, rd_d;
  seg7_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             digit_q, digit_d;
  logic [7:0]       seg_q, seg_d;
  logic [1:0]       com_q, com_d;
  logic             tick_q, tick_d;
  logic [7:0]       sel_byte, pattern;
  logic             sel_raw;
  logic [1:0]       com_on;

  assign sel_byte = digit_q ? dig1_q : dig0_q;
  assign sel_raw  = digit_q ? ctrl_q[CTRL_RAW1] : ctrl_q[CTRL_RAW0];
  assign com_on   = digit_q ? 2'b10 : 2'b01;

  seg7_hex_decode u_dec (
    .nibble   (sel_byte[3:0]),
    .dp       (sel_byte[7]),
    .raw      (sel_raw),
    .raw_byte (sel_byte),
    .pattern  (pattern)
  );

  always_comb begin
    rd_d = 8'h00;
    case (addr)
      ADDR_DIG0: rd_d = dig0_q;
      ADDR_DIG1: rd_d = dig1_q;
      ADDR_CTRL: rd_d = ctrl_q;
      default:   rd_d = 8'h00;
    endcase
  end

  // The pattern latched on the last BLANK cycle is held in seg_q for the whole
  // window, so register writes during SHOW cannot tear the displayed digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    seg_d   = seg_q;
    com_d   = com_q;
    tick_d  = 1'b0;
    if (!ctrl_q[CTRL_EN]) begin
      state_d = IDLE;
      cnt_d   = '0;
      digit_d = 1'b0;
      seg_d   = SEG_OFF;
      com_d   = COM_OFF;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
          digit_d = 1'b0;
          seg_d   = SEG_OFF;
          com_d   = COM_OFF;
        end
        BLANK: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
            cnt_d   = DIGIT_LOAD;
            seg_d   = SEG_ACTIVE_LOW ? ~pattern : pattern;
            com_d   = COM_ACTIVE_LOW ? ~com_on : com_on;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SHOW: begin
          // Raised one cycle early so the pulse coincides with the final digit 1 cycle.
          tick_d = digit_q && (cnt_q == CNT_W'(1));
          if (cnt_q == '0) begin
            state_d = BLANK;
            cnt_d   = BLANK_LOAD;
            digit_d = ~digit_q;
            seg_d   = SEG_OFF;
            com_d   = COM_OFF;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz_i) begin
    if (reset) begin
      dig0_q  <= 8'h00;
      dig1_q  <= 8'h00;
      ctrl_q  <= 8'h00;
      rd_q    <= 8'h00;
      state_q <= IDLE;
      cnt_q   <= '0;
      digit_q <= 1'b0;
      seg_q   <= SEG_OFF;
      com_q   <= COM_OFF;
      tick_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_DIG0: dig0_q <= wr_data;
          ADDR_DIG1: dig1_q <= wr_data;
          ADDR_CTRL: ctrl_q <= wr_data;
          default: ;
        endcase
      end
      rd_q    <= rd_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
      tick_q  <= tick_d;
    end
  end

  assign rd_data    = rd_q;
  assign SEG_o      = seg_q;
  assign COM_o      = com_q;
  assign frame_tick = tick_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 8-cycle windows and 2-cycle blanking.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int W = 20;  // {rd_valid, rd[7:0], tick, com[1:0], seg[7:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic [7:0]  SEG_o;
  logic [1:0]  COM_o;
  logic        frame_tick;
  seg7_state_e dbg_state;

  logic [W-1:0] exp_q[$];
  int n_pass = 0;
  int n_chk  = 0;

  seg7_scan_ctrl #(
    .DIGIT_CYCLES   (8),
    .BLANK_CYCLES   (2),
    .COM_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_50MHz_i (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .SEG_o       (SEG_o),
    .COM_o       (COM_o),
    .frame_tick  (frame_tick),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] o(input logic [1:0] com, input logic [7:0] seg, input logic t);
    return {1'b0, 8'h00, t, com, seg};
  endfunction

  function automatic logic [W-1:0] blank();
    return o(2'b11, 8'hFF, 1'b0);
  endfunction

  function automatic logic [W-1:0] r(input logic [7:0] d);
    return {1'b1, d, 1'b0, 2'b11, 8'hFF};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Push the expectation, advance one edge, then pop and compare.
  task automatic cyc(input string tag, input logic [W-1:0] e);
    logic [W-1:0] x;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check({tag, "/out"}, {9'd0, frame_tick, COM_o, SEG_o}, {9'd0, x[10:0]});
    if (x[19]) check({tag, "/rd"}, {12'd0, rd_data}, {12'd0, x[18:11]});
  endtask

  task automatic wr(input string tag, input logic [1:0] a, input logic [7:0] d, input logic [W-1:0] e);
    wr_en = 1'b1; addr = a; wr_data = d;
    cyc(tag, e);
    wr_en = 1'b0;
  endtask

  // Frame index i: 0-1 blank, 2-9 digit 0, 10-11 blank, 12-19 digit 1 (tick at 19).
  // wr_at names the frame edge at which an optional register write is captured.
  task automatic frame(input string tag, input logic [7:0] s0, input logic [7:0] s1, input int n,
                       input int wr_at, input logic [1:0] wa, input logic [7:0] wd);
    logic [W-1:0] e;
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        wr_en = 1'b1; addr = wa; wr_data = wd;
      end
      if (i < 2 || (i >= 10 && i < 12)) e = blank();
      else if (i < 10) e = o(2'b10, s0, 1'b0);
      else e = o(2'b01, s1, i == 19);
      cyc(tag, e);
      wr_en = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; addr = 2'd0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {9'd0, frame_tick, COM_o, SEG_o}, {9'd0, 1'b0, 2'b11, 8'hFF});
    check("reset_state", {18'd0, dbg_state}, {18'd0, IDLE});
    reset = 1'b0;
    cyc("reset_rd", r(8'h00));

    for (int i = 0; i < 100; i++) cyc("idle", blank());

    wr("wr_dig0", ADDR_DIG0, 8'h00, blank());
    wr("wr_dig1", ADDR_DIG1, 8'h8A, blank());
    wr("wr_ctrl", ADDR_CTRL, 8'h01, blank());
    frame("scan_a", 8'hC0, 8'h08, 20, -1, 2'd0, 8'h00);
    frame("scan_b", 8'hC0, 8'h08, 20, -1, 2'd0, 8'h00);

    frame("tear_mid", 8'hC0, 8'h08, 20, 5, ADDR_DIG0, 8'h08);
    frame("tear_new", 8'h80, 8'h08, 20, 2, ADDR_DIG0, 8'h00);
    frame("tear_blank", 8'hC0, 8'h08, 20, -1, 2'd0, 8'h00);

    frame("raw_ctrl", 8'hC0, 8'h08, 20, 5, ADDR_CTRL, 8'h03);
    frame("raw_zero", 8'hFF, 8'h08, 20, 5, ADDR_DIG0, 8'h49);
    frame("raw_49", 8'hB6, 8'h08, 20, -1, 2'd0, 8'h00);

    frame("disable", 8'hB6, 8'h08, 16, 15, ADDR_CTRL, 8'h00);
    for (int i = 0; i < 6; i++) cyc("disabled", blank());
    check("disabled_state", {18'd0, dbg_state}, {18'd0, IDLE});

    wr("wr_rsvd", 2'd3, 8'h55, blank());
    addr = 2'd3;
    cyc("rd_rsvd_after_wr", r(8'h00));
    wr("wr_ctrl_f8", ADDR_CTRL, 8'hF8, r(8'h00));
    addr = ADDR_CTRL;
    cyc("rd_ctrl_after_wr", r(8'hF8));
    addr = ADDR_DIG0; cyc("rd_dig0", r(8'h49));
    addr = ADDR_DIG1; cyc("rd_dig1", r(8'h8A));
    addr = ADDR_CTRL; cyc("rd_ctrl", r(8'hF8));
    addr = 2'd3;      cyc("rd_rsvd", r(8'h00));

    wr("reenable", ADDR_CTRL, 8'h01, blank());
    frame("reenable_scan", 8'h90, 8'h08, 20, -1, 2'd0, 8'h00);

    frame("pre_reset", 8'h90, 8'h08, 6, -1, 2'd0, 8'h00);
    reset = 1'b1;
    cyc("mid_reset", r(8'h00));
    reset = 1'b0;
    addr = ADDR_DIG0; cyc("post_rst_dig0", r(8'h00));
    addr = ADDR_DIG1; cyc("post_rst_dig1", r(8'h00));
    addr = ADDR_CTRL; cyc("post_rst_ctrl", r(8'h00));
    for (int i = 0; i < 25; i++) cyc("post_rst_idle", blank());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
